// File: rtl/ctech_lib_hs4_pkg.sv
// Shared definitions for the 4-phase handshake responder: FSM states and
// the legal range of the request synchronizer depth.
`timescale 1ns/1ps
package ctech_lib_hs4_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ACK_HI      = 2'd1,
    ACK_LO_WAIT = 2'd2
  } ctech_hs4_state_t;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Out-of-range depths are pulled back into the legal range.
  function automatic int clamp_sync_stages(input int n);
    if (n < SYNC_STAGES_MIN) return SYNC_STAGES_MIN;
    if (n > SYNC_STAGES_MAX) return SYNC_STAGES_MAX;
    return n;
  endfunction

endpackage

// File: rtl/ctech_lib_doublesync_rstb.sv
// Multi-flop synchronizer with asynchronous active-low reset; the only
// consumer of the asynchronous request line.
`timescale 1ns/1ps
module ctech_lib_doublesync_rstb #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstb,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ctech_lib_hs4_responder.sv
// 4-phase handshake responder: captures an asynchronous initiator's payload
// into a one-word output buffer and completes the req/ack handshake.
`timescale 1ns/1ps
module ctech_lib_hs4_responder
  import ctech_lib_hs4_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              req_a,
  input  logic [DATA_W-1:0] data_a,
  output logic              ack,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic [15:0]       xfer_cnt
);

  ctech_hs4_state_t state;
  logic             req_s;
  logic             buf_free;

  ctech_lib_doublesync_rstb #(
    .STAGES(clamp_sync_stages(SYNC_STAGES))
  ) u_req_sync (
    .clk  (clk),
    .rstb (rstb),
    .d    (req_a),
    .q    (req_s)
  );

  assign buf_free = !out_valid || out_ready;
  assign busy     = (state != IDLE) || out_valid;

  // A pop and a new capture may share an edge; the capture assignment
  // below wins so out_valid stays high with the new word.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= IDLE;
      ack       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      xfer_cnt  <= 16'd0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (req_s && buf_free) begin
            out_data  <= data_a;
            out_valid <= 1'b1;
            ack       <= 1'b1;
            state     <= ACK_HI;
          end
        end
        ACK_HI: begin
          if (!req_s) begin
            ack      <= 1'b0;
            xfer_cnt <= xfer_cnt + 16'd1;
            state    <= ACK_LO_WAIT;
          end
        end
        ACK_LO_WAIT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctech_lib_hs4_responder.sv
// Self-checking bench: an initiator model plus an in-order word queue and a
// transfer counter serve as the reference for the responder.
`timescale 1ns/1ps
module tb_ctech_lib_hs4_responder;

  localparam int DATA_W      = 32;
  localparam int SYNC_STAGES = 2;

  logic              clk       = 1'b0;
  logic              rstb      = 1'b1;
  logic              req_a     = 1'b0;
  logic [DATA_W-1:0] data_a    = '0;
  logic              out_ready = 1'b0;
  logic              ack;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic [15:0]       xfer_cnt;

  int                vectors     = 0;
  int                miscompares = 0;
  int                pops        = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_w;
  logic [15:0]       exp_cnt     = 16'd0;
  bit                ready_rand  = 1'b0;

  ctech_lib_hs4_responder #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rstb      (rstb),
    .req_a     (req_a),
    .data_a    (data_a),
    .ack       (ack),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  // A word seen valid and ready here is consumed at the next rising edge.
  always @(negedge clk) begin
    if (rstb && out_valid && out_ready) begin
      vectors++;
      pops++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL pop_extra: got word %h, required none pending", out_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (out_data !== exp_w) begin
          miscompares++;
          $display("[TB] FAIL pop_data: got %h, required %h", out_data, exp_w);
        end
      end
    end
  end

  // 4-phase ordering: ack may only rise while req is high and fall while it is low.
  always @(ack) begin
    if (rstb === 1'b1) begin
      vectors++;
      if (req_a !== ack) begin
        miscompares++;
        $display("[TB] FAIL hs_order: ack moved to %b with req_a=%b, required req_a=%b", ack, req_a, ack);
      end
    end
  end

  always @(posedge clk) begin
    if (ready_rand) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 out_ready = r;
  endtask

  task automatic wait_ack(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (ack !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (ack !== lvl) begin
      miscompares++;
      $display("[TB] FAIL %s_timeout: ack=%b, required %b within %0d cycles", tag, ack, lvl, budget);
    end
  endtask

  task automatic do_transfer(input logic [DATA_W-1:0] d, input int budget, input string tag);
    data_a = d;
    exp_q.push_back(d);
    req_a = 1'b1;
    wait_ack(1'b1, budget, tag);
    req_a = 1'b0;
    wait_ack(1'b0, budget, tag);
    exp_cnt++;
  endtask

  task automatic check_cnt(input string tag);
    vectors++;
    if (xfer_cnt !== exp_cnt) begin
      miscompares++;
      $display("[TB] FAIL %s_cnt: xfer_cnt=%h, required %h", tag, xfer_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset();
    #3 rstb = 1'b0;
    #2;
    vectors++;
    if ({ack, out_valid, busy, out_data, xfer_cnt} !== {3'b000, {DATA_W{1'b0}}, 16'h0}) begin
      miscompares++;
      $display("[TB] FAIL reset_state: ack=%b valid=%b busy=%b data=%h cnt=%h, required all zero",
               ack, out_valid, busy, out_data, xfer_cnt);
    end
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int e;
    set_ready(1'b1);
    @(posedge clk);
    #1 data_a = 32'hDEADBEEF;
    exp_q.push_back(32'hDEADBEEF);
    req_a = 1'b1;
    for (e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (ack !== (e == 3)) begin
        miscompares++;
        $display("[TB] FAIL basic_latency: edge %0d ack=%b, required %b", e, ack, (e == 3));
      end
    end
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF) begin
      miscompares++;
      $display("[TB] FAIL basic_capture: valid=%b data=%h, required 1 deadbeef", out_valid, out_data);
    end
    req_a = 1'b0;
    e = 0;
    while (ack !== 1'b0 && e < 3) begin
      @(posedge clk);
      #1;
      e++;
    end
    vectors++;
    if (ack !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_ack_fall: ack=%b after 3 edges, required 0", ack);
    end
    exp_cnt++;
    check_cnt("basic");
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] a_w, b_w;
    a_w = 32'hA5A5_0001;
    b_w = 32'h5A5A_0002;
    set_ready(1'b0);
    do_transfer(a_w, 50, "bp_first");
    repeat (2) @(negedge clk);
    data_a = b_w;
    exp_q.push_back(b_w);
    req_a = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    vectors++;
    if (ack !== 1'b0 || out_valid !== 1'b1 || out_data !== a_w) begin
      miscompares++;
      $display("[TB] FAIL bp_hold: ack=%b valid=%b data=%h, required 0 1 %h", ack, out_valid, out_data, a_w);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (ack !== 1'b1 || out_valid !== 1'b1 || out_data !== b_w) begin
      miscompares++;
      $display("[TB] FAIL bp_swap: ack=%b valid=%b data=%h, required 1 1 %h", ack, out_valid, out_data, b_w);
    end
    req_a = 1'b0;
    wait_ack(1'b0, 50, "bp_second");
    exp_cnt++;
    repeat (3) @(negedge clk);
    check_cnt("bp");
  endtask

  task automatic test_back_to_back();
    int pops0;
    set_ready(1'b1);
    @(negedge clk);
    pops0 = pops;
    for (int i = 0; i < 4; i++) begin
      do_transfer({8'(i + 1), 24'($urandom)}, 50, "b2b");
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (pops - pops0 != 4 || exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL b2b_words: delivered %0d, pending %0d, required 4 and 0", pops - pops0, exp_q.size());
    end
    check_cnt("b2b");
  endtask

  task automatic test_reset_mid();
    set_ready(1'b0);
    @(negedge clk);
    data_a = $urandom;
    exp_q.push_back(data_a);
    req_a = 1'b1;
    wait_ack(1'b1, 50, "rst_mid");
    #3 rstb = 1'b0;
    #1;
    vectors++;
    if ({ack, out_valid, out_data, xfer_cnt} !== {2'b00, {DATA_W{1'b0}}, 16'h0}) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_clear: ack=%b valid=%b data=%h cnt=%h, required all zero",
               ack, out_valid, out_data, xfer_cnt);
    end
    exp_q.delete();
    exp_cnt = 16'd0;
    req_a = 1'b0;
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || ack !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_idle: busy=%b ack=%b, required 0 0", busy, ack);
    end
  endtask

  task automatic test_wrap();
    set_ready(1'b1);
    @(negedge clk);
    force dut.xfer_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.xfer_cnt;
    exp_cnt = 16'hFFFF;
    #1;
    check_cnt("wrap_preload");
    do_transfer(32'h0BAD_F00D, 50, "wrap");
    check_cnt("wrap");
    vectors++;
    if (xfer_cnt !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL wrap_zero: xfer_cnt=%h, required 0000", xfer_cnt);
    end
  endtask

  task automatic test_jitter();
    ready_rand = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      #($urandom_range(0, 25000) / 1000.0);
      data_a = $urandom;
      exp_q.push_back(data_a);
      req_a = 1'b1;
      wait_ack(1'b1, 500, "jit");
      #($urandom_range(0, 25000) / 1000.0);
      req_a = 1'b0;
      wait_ack(1'b0, 500, "jit");
      exp_cnt++;
    end
    ready_rand = 1'b0;
    set_ready(1'b1);
    repeat (6) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL jit_lost: %0d words undelivered, required 0", exp_q.size());
    end
    check_cnt("jit");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_jitter();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
